// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg
//   Pipeline stage register with a valid/ready handshake and a two-entry
//   skid buffer. in_ready depends only on registered state, so a
//   back-pressure change on out_ready never forms a combinational path
//   through the stage. A synchronous flush clears all held entries.
//
// Parameters
//   WIDTH      payload width in bits
//   RESET_VAL  value held in the data registers when they are empty
//
// Ports
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   flush      synchronous clear of all held entries (priority over transfers)
//   in_valid   upstream word present
//   in_ready   stage can accept a word
//   in_data    upstream payload
//   out_valid  downstream word present
//   out_ready  downstream accepts
//   out_data   downstream payload (always the main register)
//   occ        current occupancy, 0..2
module pipe_skid_reg #(
    parameter int unsigned          WIDTH     = 32,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occ
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire;
    logic             out_fire;

    // Outputs are decoded from registered state only.
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != TWO);
    assign out_data  = main_q;
    assign occ       = state_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Any in_fire this cycle is accepted and dropped.
            state_d = EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = TWO;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                        main_d  = RESET_VAL;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a pop can occur.
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = RESET_VAL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = RESET_VAL;
                    skid_d  = RESET_VAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg
//   Directed and randomized stimulus for pipe_skid_reg, checked every cycle
//   against a FIFO-queue reference model of at most two entries.
module tb_pipe_skid_reg;

    localparam int unsigned      W  = 32;
    localparam logic [W-1:0]     RV = 32'h0;

    logic         clk = 1'b0;
    logic         resetn;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occ;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    // Reference model: words held by the stage, oldest first.
    logic [W-1:0] q[$];

    pipe_skid_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occ       (occ)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
        chk("in_ready",  {31'b0, in_ready},  {31'b0, q.size() < 2});
        chk("occ",       {30'b0, occ},       q.size());
        chk("out_data",  out_data,           (q.size() != 0) ? q[0] : RV);
    endtask

    // Advance one cycle, update the model from the inputs seen at the edge,
    // then check 1 time unit later.
    task automatic tick();
        logic fire_in, fire_out;
        @(posedge clk);
        if (!resetn) begin
            q.delete();
        end else begin
            fire_in  = in_valid && (q.size() < 2);
            fire_out = out_ready && (q.size() != 0);
            if (flush) begin
                q.delete();
            end else begin
                if (fire_out) void'(q.pop_front());
                if (fire_in)  q.push_back(in_data);
            end
        end
        #1;
        check_model();
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    initial begin
        // Reset with an offered word: nothing may be captured.
        resetn = 1'b0;
        drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        #1;
        check_model();
        repeat (3) tick();
        chk("reset out_data", out_data, 32'h0);

        // Release away from the edge; the first edge may accept a word.
        resetn = 1'b1;
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        tick();
        chk("first word", out_data, 32'h1234_5678);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();

        // Streaming with out_ready held high.
        drive(1'b1, 32'h1, 1'b1, 1'b0); tick();
        chk("stream 1", out_data, 32'h1);
        drive(1'b1, 32'h2, 1'b1, 1'b0); tick();
        chk("stream 2", out_data, 32'h2);
        drive(1'b1, 32'h3, 1'b1, 1'b0); tick();
        chk("stream 3", out_data, 32'h3);
        chk("stream occ", {30'b0, occ}, 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick();

        // Skid: second word absorbed under back-pressure.
        drive(1'b1, 32'hA, 1'b0, 1'b0); tick();
        drive(1'b1, 32'hB, 1'b0, 1'b0); tick();
        chk("skid occ", {30'b0, occ}, 32'd2);
        chk("skid in_ready", {31'b0, in_ready}, 32'd0);
        chk("skid hold A", out_data, 32'hA);
        drive(1'b1, 32'hEE, 1'b0, 1'b0); tick();
        chk("skid still A", out_data, 32'hA);
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
        chk("skid pop B", out_data, 32'hB);
        chk("skid recover", {31'b0, in_ready}, 32'd1);
        tick();
        chk("skid drained", {31'b0, out_valid}, 32'd0);

        // Flush from TWO with a word offered alongside.
        drive(1'b1, 32'hA, 1'b0, 1'b0); tick();
        drive(1'b1, 32'hB, 1'b0, 1'b0); tick();
        drive(1'b1, 32'hC, 1'b0, 1'b1); tick();
        chk("flush occ", {30'b0, occ}, 32'd0);
        chk("flush data", out_data, RV);
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
        tick();
        chk("flush no C", {31'b0, out_valid}, 32'd0);

        // Flush from ONE while a word fires in: it is discarded; new word next.
        drive(1'b1, 32'h55, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h66, 1'b0, 1'b1); tick();
        drive(1'b1, 32'h77, 1'b0, 1'b0); tick();
        chk("post-flush word", out_data, 32'h77);

        // Asynchronous reset mid-operation with two held words.
        drive(1'b1, 32'h88, 1'b0, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        resetn = 1'b0;
        q.delete();
        #1;
        check_model();
        drive(1'b1, 32'h99, 1'b1, 1'b0);
        tick();
        resetn = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("after reset empty", {31'b0, out_valid}, 32'd0);

        // Random stall and flush traffic.
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 31) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
